fetch_queue_unit: RTL

//  Parametrised instruction fetch front end between the ICache and the decoder.

---
 rtl/fetch_queue_unit_if.sv | 59 +++++
 rtl/fetch_queue_unit.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/fetch_queue_unit_if.sv
// Fetch front-end bundle: predictor query, redirect, ICache read port and the
// decoder-side dequeue port.
//   master : the fetch unit (drives pred_query_pc, icache_*, deq_*, count)
//   slave  : the surrounding pipeline / ICache / decoder
interface fetch_queue_unit_if #(
   parameter int unsigned XLEN  = 32,
   parameter int unsigned DEPTH = 4
);
   localparam int unsigned CntW = $clog2(DEPTH) + 1;

   logic [XLEN-1:0] pred_query_pc;
   logic [XLEN-1:0] pred_pc;
   logic            clr;
   logic [XLEN-1:0] target_pc;
   logic [XLEN-1:0] icache_addr;
   logic            icache_rn;
   logic [XLEN-1:0] icache_inst;
   logic            icache_ready;
   logic            deq_valid;
   logic [XLEN-1:0] deq_inst;
   logic [XLEN-1:0] deq_pc;
   logic [XLEN-1:0] deq_pred_pc;
   logic            deq_en;
   logic [CntW-1:0] count;

   modport master (
      output pred_query_pc,
      input  pred_pc,
      input  clr,
      input  target_pc,
      output icache_addr,
      output icache_rn,
      input  icache_inst,
      input  icache_ready,
      output deq_valid,
      output deq_inst,
      output deq_pc,
      output deq_pred_pc,
      input  deq_en,
      output count
   );

   modport slave (
      input  pred_query_pc,
      output pred_pc,
      output clr,
      output target_pc,
      input  icache_addr,
      input  icache_rn,
      output icache_inst,
      output icache_ready,
      input  deq_valid,
      input  deq_inst,
      input  deq_pc,
      input  deq_pred_pc,
      output deq_en,
      input  count
   );
endinterface

// File: rtl/fetch_queue_unit.sv
// Instruction fetch front end. Keeps a fetch PC, issues one ICache read at a time,
// follows the branch predictor for the next PC and buffers {inst, pc, pred_pc} in
// a DEPTH-entry FIFO popped by the decoder. clr flushes the FIFO, discards any
// in-flight response and restarts fetch at target_pc.
// Ports:
//   clk   : clock
//   rst   : synchronous active-high reset (acts regardless of rdy)
//   rdy   : global ready; low freezes all state
//   bus_io: fetch_queue_unit_if.master (predictor, redirect, ICache, dequeue)
module fetch_queue_unit #(
   parameter int unsigned    XLEN     = 32,
   parameter int unsigned    DEPTH    = 4,
   parameter logic [XLEN-1:0] RESET_PC = '0
) (
   input logic                clk,
   input logic                rst,
   input logic                rdy,
   fetch_queue_unit_if.master bus_io
);
   localparam int unsigned PtrW = $clog2(DEPTH);
   localparam int unsigned CntW = PtrW + 1;
   localparam logic [CntW-1:0] Full = CntW'(DEPTH);

   typedef enum logic [1:0] {StIdle, StWait, StDrop} state_e;

   state_e          state_q, state_d;
   logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
   logic            rn_q, rn_d;
   logic [XLEN-1:0] addr_q, addr_d;
   logic [PtrW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
   logic [CntW-1:0] count_q, count_d, count_nx;
   logic [XLEN-1:0] inst_q [DEPTH];
   logic [XLEN-1:0] pc_q   [DEPTH];
   logic [XLEN-1:0] ppc_q  [DEPTH];
   logic            enq, deq;

   // A clr cycle has no queue effect, so both strobes are masked by it.
   assign enq      = (state_q == StWait) && bus_io.icache_ready && !bus_io.clr;
   assign deq      = bus_io.deq_en && (count_q != '0) && !bus_io.clr;
   assign count_nx = count_q + CntW'(enq) - CntW'(deq);

   always_comb begin
      state_d    = state_q;
      fetch_pc_d = fetch_pc_q;
      rn_d       = rn_q;
      addr_d     = addr_q;
      count_d    = count_nx;
      rd_ptr_d   = deq ? rd_ptr_q + PtrW'(1) : rd_ptr_q;
      wr_ptr_d   = enq ? wr_ptr_q + PtrW'(1) : wr_ptr_q;
      if (bus_io.clr) begin
         count_d    = '0;
         rd_ptr_d   = '0;
         wr_ptr_d   = '0;
         fetch_pc_d = bus_io.target_pc;
         unique case (state_q)
            StIdle: begin
               rn_d    = 1'b1;
               addr_d  = bus_io.target_pc;
               state_d = StWait;
            end
            StWait: begin
               // Response landing in the clr cycle is stale: reissue at once.
               // Otherwise the old request stays on the bus until it returns.
               if (bus_io.icache_ready) begin
                  addr_d = bus_io.target_pc;
               end else begin
                  state_d = StDrop;
               end
            end
            StDrop: begin
               if (bus_io.icache_ready) begin
                  addr_d  = bus_io.target_pc;
                  state_d = StWait;
               end
            end
            default: state_d = StIdle;
         endcase
      end else begin
         unique case (state_q)
            StIdle: begin
               if (count_q < Full) begin
                  rn_d    = 1'b1;
                  addr_d  = fetch_pc_q;
                  state_d = StWait;
               end
            end
            StWait: begin
               if (bus_io.icache_ready) begin
                  fetch_pc_d = bus_io.pred_pc;
                  // Keep fetching back-to-back only while a slot remains free.
                  if (count_nx < Full) begin
                     addr_d = bus_io.pred_pc;
                  end else begin
                     rn_d    = 1'b0;
                     state_d = StIdle;
                  end
               end
            end
            StDrop: begin
               if (bus_io.icache_ready) begin
                  addr_d  = fetch_pc_q;
                  state_d = StWait;
               end
            end
            default: state_d = StIdle;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= StIdle;
         fetch_pc_q <= RESET_PC;
         rn_q       <= 1'b0;
         addr_q     <= RESET_PC;
         rd_ptr_q   <= '0;
         wr_ptr_q   <= '0;
         count_q    <= '0;
         for (int i = 0; i < int'(DEPTH); i++) begin
            inst_q[i] <= '0;
            pc_q[i]   <= '0;
            ppc_q[i]  <= '0;
         end
      end else if (rdy) begin
         state_q    <= state_d;
         fetch_pc_q <= fetch_pc_d;
         rn_q       <= rn_d;
         addr_q     <= addr_d;
         rd_ptr_q   <= rd_ptr_d;
         wr_ptr_q   <= wr_ptr_d;
         count_q    <= count_d;
         if (enq) begin
            inst_q[wr_ptr_q] <= bus_io.icache_inst;
            pc_q[wr_ptr_q]   <= fetch_pc_q;
            ppc_q[wr_ptr_q]  <= bus_io.pred_pc;
         end
      end
   end

   assign bus_io.pred_query_pc = fetch_pc_q;
   assign bus_io.icache_rn     = rn_q;
   assign bus_io.icache_addr   = addr_q;
   assign bus_io.count         = count_q;
   assign bus_io.deq_valid     = (count_q != '0);
   assign bus_io.deq_inst      = inst_q[rd_ptr_q];
   assign bus_io.deq_pc        = pc_q[rd_ptr_q];
   assign bus_io.deq_pred_pc   = ppc_q[rd_ptr_q];
endmodule
